// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//
// Direct-mapped branch target buffer (BTB) with 2-bit saturating counters,
// plus misprediction detection / redirect for the EX stage and resolve and
// misprediction event counters.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : asynchronous, active-low reset
//   if_pc          : fetch-stage PC to predict
//   pred_taken     : combinational taken prediction for if_pc
//   pred_target    : predicted next PC (if_pc+4 when not predicted taken)
//   ex_valid       : EX holds a resolving control-flow instruction
//   ex_stall       : EX stalled, resolution deferred
//   ex_is_jump     : EX op is JAL/JALR (always taken)
//   ex_pc          : PC of the EX instruction
//   ex_bcond       : actual conditional-branch outcome
//   ex_target      : actual taken target
//   ex_pred_taken  : prediction carried with the instruction
//   ex_pred_target : predicted target carried with the instruction
//   flush          : kill IF/ID and load redirect_pc (combinational)
//   redirect_pc    : correct next PC when flush=1, else 0
//   br_count       : resolved control-flow instructions (saturating)
//   mp_count       : mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
   parameter int ENTRIES = 16,
   parameter int IDX     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        ex_is_jump,
   input  logic [31:0] ex_pc,
   input  logic        ex_bcond,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mp_count
);

   localparam int TAGW = 32 - IDX - 2;

   // BTB storage
   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] valid_d;
   logic [TAGW-1:0]    tag_q    [ENTRIES];
   logic [TAGW-1:0]    tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   // Event counters
   logic [31:0] br_count_q;
   logic [31:0] br_count_d;
   logic [31:0] mp_count_q;
   logic [31:0] mp_count_d;

   // Lookup side
   logic [IDX-1:0]  if_idx_s;
   logic [TAGW-1:0] if_tag_s;
   logic            if_hit_s;

   // Resolve side
   logic [IDX-1:0]  ex_idx_s;
   logic [TAGW-1:0] ex_tag_s;
   logic            ex_hit_s;
   logic            resolve_s;
   logic            actual_taken_s;
   logic            mispredict_s;

   // Saturating increment of a 2-bit counter
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      logic [1:0] r;
      case (c)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b11;
         default: r = 2'b01;
      endcase
      return r;
   endfunction

   // Saturating decrement of a 2-bit counter
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      logic [1:0] r;
      case (c)
         2'b00:   r = 2'b00;
         2'b01:   r = 2'b00;
         2'b10:   r = 2'b01;
         2'b11:   r = 2'b10;
         default: r = 2'b01;
      endcase
      return r;
   endfunction

   // Fetch-side lookup; reads only registered BTB state so a same-cycle
   // update to the same index is not visible until the next cycle.
   always_comb begin
      if_idx_s = if_pc[IDX+1:2];
      if_tag_s = if_pc[31:IDX+2];
      if_hit_s = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
      // Gating with reset keeps the prediction quiet while reset is held.
      if (reset && if_hit_s && ctr_q[if_idx_s][1]) begin
         pred_taken  = 1'b1;
         pred_target = target_q[if_idx_s];
      end else begin
         pred_taken  = 1'b0;
         pred_target = if_pc + 32'd4;
      end
   end

   // Resolve qualification, misprediction detection and redirect target
   always_comb begin
      resolve_s      = reset && ex_valid && !ex_stall;
      actual_taken_s = ex_is_jump || ex_bcond;
      // A correct taken/not-taken guess with the wrong target is still a miss.
      mispredict_s   = resolve_s &&
                       ((ex_pred_taken != actual_taken_s) ||
                        (ex_pred_taken && actual_taken_s && (ex_pred_target != ex_target)));
      flush          = mispredict_s;
      if (mispredict_s) begin
         if (actual_taken_s) begin
            redirect_pc = ex_target;
         end else begin
            redirect_pc = ex_pc + 32'd4;
         end
      end else begin
         redirect_pc = 32'd0;
      end
   end

   // Next-state for the BTB: at most one entry (ex_pc's index) changes per resolve
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < ENTRIES; i++) begin
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end
      ex_idx_s = ex_pc[IDX+1:2];
      ex_tag_s = ex_pc[31:IDX+2];
      ex_hit_s = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
      if (resolve_s) begin
         if (ex_hit_s) begin
            if (actual_taken_s) begin
               // Jumps are unconditionally taken, so pin them to strong-taken;
               // the target is always refreshed since JALR targets move.
               if (ex_is_jump) begin
                  ctr_d[ex_idx_s] = 2'b11;
               end else begin
                  ctr_d[ex_idx_s] = ctr_inc(ctr_q[ex_idx_s]);
               end
               target_d[ex_idx_s] = ex_target;
            end else begin
               ctr_d[ex_idx_s] = ctr_dec(ctr_q[ex_idx_s]);
            end
         end else begin
            if (actual_taken_s) begin
               // Allocate, evicting whatever aliased into this slot.
               valid_d[ex_idx_s]  = 1'b1;
               tag_d[ex_idx_s]    = ex_tag_s;
               target_d[ex_idx_s] = ex_target;
               if (ex_is_jump) begin
                  ctr_d[ex_idx_s] = 2'b11;
               end else begin
                  ctr_d[ex_idx_s] = 2'b10;
               end
            end else begin
               // Not-taken misses are not worth a BTB slot.
               valid_d[ex_idx_s] = valid_q[ex_idx_s];
            end
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Next-state for the saturating event counters
   always_comb begin
      br_count_d = br_count_q;
      mp_count_d = mp_count_q;
      if (resolve_s && (br_count_q != 32'hFFFF_FFFF)) begin
         br_count_d = br_count_q + 32'd1;
      end else begin
         br_count_d = br_count_q;
      end
      if (mispredict_s && (mp_count_q != 32'hFFFF_FFFF)) begin
         mp_count_d = mp_count_q + 32'd1;
      end else begin
         mp_count_d = mp_count_q;
      end
   end

   // State registers; reset clears the BTB to invalid/weak-not-taken
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= '0;
         br_count_q <= 32'd0;
         mp_count_q <= 32'd0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q    <= valid_d;
         br_count_q <= br_count_d;
         mp_count_q <= mp_count_d;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

   assign br_count = br_count_q;
   assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Directed stimulus for branch_predict_ctrl. Each driven cycle pushes the
// hand-computed expected outputs into a queue; a monitor samples the DUT on
// the falling edge and compares against the head of the queue.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_stall;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic        ex_bcond;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mp_count;

   typedef struct {
      string       name;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      logic [31:0] rpc;
      logic [31:0] brc;
      logic [31:0] mpc;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   branch_predict_ctrl #(.ENTRIES(16), .IDX(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .ex_is_jump     (ex_is_jump),
      .ex_pc          (ex_pc),
      .ex_bcond       (ex_bcond),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mp_count       (mp_count)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   // Drive one cycle of inputs just after the rising edge and queue the
   // outputs expected at the following falling edge.
   task automatic step(input string nm, input logic rst, input logic [31:0] ipc,
                       input logic v, input logic st, input logic j,
                       input logic [31:0] epc, input logic bc, input logic [31:0] tgt,
                       input logic ept, input logic [31:0] eptg,
                       input logic xpt, input logic [31:0] xptg,
                       input logic xfl, input logic [31:0] xrpc,
                       input logic [31:0] xbr, input logic [31:0] xmp);
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      if_pc          = ipc;
      ex_valid       = v;
      ex_stall       = st;
      ex_is_jump     = j;
      ex_pc          = epc;
      ex_bcond       = bc;
      ex_target      = tgt;
      ex_pred_taken  = ept;
      ex_pred_target = eptg;
      e.name = nm; e.pt = xpt; e.ptgt = xptg; e.fl = xfl;
      e.rpc = xrpc; e.brc = xbr; e.mpc = xmp;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s: actual=0x%08h required=0x%08h", nm, fld, act, req);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
            cmp(e.name, "pred_target", pred_target,         e.ptgt);
            cmp(e.name, "flush",       {31'd0, flush},      {31'd0, e.fl});
            cmp(e.name, "redirect_pc", redirect_pc,         e.rpc);
            cmp(e.name, "br_count",    br_count,            e.brc);
            cmp(e.name, "mp_count",    mp_count,            e.mpc);
         end
      end
   end

   // Directed stimulus
   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      if_pc = 32'h100;
      ex_valid = 1'b0; ex_stall = 1'b0; ex_is_jump = 1'b0;
      ex_pc = 32'd0; ex_bcond = 1'b0; ex_target = 32'd0;
      ex_pred_taken = 1'b0; ex_pred_target = 32'd0;

      //    name        rst ifpc          v     st    j     epc     bc    tgt     ept   eptg    | pt    ptgt    fl    rpc     br     mp
      step("rst_hold",  1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h0,   32'd0, 32'd0);
      step("release",   1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0,   32'd0, 32'd0);
      step("alloc",     1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80,  32'd0, 32'd0);
      step("hit",       1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   32'd1, 32'd1);
      step("nt1",       1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104, 32'd1, 32'd1);
      step("nt2",       1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h0,   32'd2, 32'd2);
      step("tk_from00", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80,  32'd3, 32'd2);
      step("ctr01",     1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0,   32'd4, 32'd3);
      step("alias",     1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 32'h140, 1'b1, 32'h180, 1'b0, 32'h144, 1'b0, 32'h144, 1'b1, 32'h180, 32'd4, 32'd3);
      step("alias_old", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0,   32'd5, 32'd4);
      step("alias_new", 1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h180, 1'b0, 32'h0,   32'd5, 32'd4);
      step("jal_alloc", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h300, 1'b0, 32'h204, 1'b0, 32'h204, 1'b1, 32'h300, 32'd5, 32'd4);
      step("jal_hit",   1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   32'd6, 32'd5);
      step("jalr_tgt",  1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h340, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h340, 32'd6, 32'd5);
      step("jalr_upd",  1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h340, 1'b0, 32'h0,   32'd7, 32'd6);
      step("jalr_ok",   1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h340, 1'b1, 32'h340, 1'b1, 32'h340, 1'b0, 32'h0,   32'd7, 32'd6);
      for (int i = 0; i < 3; i++) begin
         step("stall",  1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h304, 1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h340, 1'b0, 32'h0,   32'd8, 32'd6);
      end
      step("unstall",   1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h304, 1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h340, 1'b1, 32'h308, 32'd8, 32'd6);
      step("nt_miss",   1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h308, 1'b0, 32'h0,   32'd9, 32'd7);
      // Reset asserted between edges; the falling-edge sample precedes any rising edge.
      step("async_rst", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h0,   32'd0, 32'd0);
      #2;
      reset = 1'b0;
      step("wrap",      1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'd0, 32'd0);
      step("post_alloc",1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h240, 1'b0, 32'h204, 1'b0, 32'h204, 1'b1, 32'h240, 32'd0, 32'd0);
      step("post_hit",  1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h240, 1'b0, 32'h0,   32'd1, 32'd1);

      // Let the monitor drain the queue within a bounded number of cycles.
      for (int k = 0; k < 5; k++) begin
         if (exp_q.size() > 0) begin
            @(posedge clk);
         end
      end
      @(posedge clk);
      if (exp_q.size() != 0) begin
         $display("FAIL drain: actual=%0d required=0 pending", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + ((exp_q.size() != 0) ? 1 : 0));
      $finish;
   end

endmodule
